// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants: opcodes, the format enum and error codes.
// Used by both the instruction encoder and the decoder side.
package riscv_pkg;

    typedef enum logic [1:0] {
        FMT_I    = 2'd0,
        FMT_LOAD = 2'd1,
        FMT_S    = 2'd2,
        FMT_B    = 2'd3
    } fmt_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_IMM_RANGE = 2'b01;
    localparam logic [1:0] ERR_B_ODD     = 2'b10;

    // Major opcode for each supported format.
    function automatic logic [6:0] fmt_opcode(input fmt_e fmt);
        logic [6:0] op;
        case (fmt)
            FMT_I:    op = OPC_OP_IMM;
            FMT_LOAD: op = OPC_LOAD;
            FMT_S:    op = OPC_STORE;
            default:  op = OPC_BRANCH;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Small DEPTH-entry FIFO holding {instr, addr} pairs for the encoder output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Reset clears only the pointers; entry contents are don't-care while empty.
module instr_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head entry; forced to zero while empty so reset shows a clean output.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Read/write pointers with wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Storage for one slot, written when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder: packs decoded fields (I/LOAD/S/B) into
// 32-bit words, tags each with a sequential byte address and queues them.
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN enables immediate range /
// alignment rejection with a one-cycle error pulse; without it immediates are
// truncated and the error outputs are tied low.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               base_load,
    input  logic [31:0]        base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_fmt,
    input  logic [2:0]         in_funct3,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_addr,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic [COUNT_W-1:0] count
);
    fmt_e               fmt;
    logic [31:0]        enc_instr;
    logic               accept;
    logic               reject;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [63:0]        fifo_rd_data;
    logic [31:0]        addr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               imm_unused;

    assign fmt        = fmt_e'(in_fmt);
    // Upper immediate bits only matter to the range check.
    assign imm_unused = &{1'b0, in_imm[31:13]};

    // Field packing; the immediate is scattered per format.
    always_comb begin
        enc_instr = '0;
        case (fmt)
            FMT_I, FMT_LOAD: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd,
                                          fmt_opcode(fmt)};
            FMT_S:           enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                          in_imm[4:0], fmt_opcode(fmt)};
            FMT_B:           enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                                          in_funct3, in_imm[4:1], in_imm[11],
                                          fmt_opcode(fmt)};
            default:         enc_instr = '0;
        endcase
    end

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !reject;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic [1:0] rej_code;
    logic       err_valid_reg;
    logic [1:0] err_code_reg;

    // Immediate legality; for B the range test takes precedence over oddness.
    always_comb begin
        reject   = 1'b0;
        rej_code = ERR_NONE;
        if (fmt == FMT_B) begin
            if ($signed(in_imm) < -32'sd4096 || $signed(in_imm) > 32'sd4094) begin
                reject   = 1'b1;
                rej_code = ERR_IMM_RANGE;
            end else if (in_imm[0]) begin
                reject   = 1'b1;
                rej_code = ERR_B_ODD;
            end
        end else if ($signed(in_imm) < -32'sd2048 || $signed(in_imm) > 32'sd2047) begin
            reject   = 1'b1;
            rej_code = ERR_IMM_RANGE;
        end
    end

    // One-cycle error pulse following a consumed but rejected request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            err_valid_reg <= accept && reject;
            err_code_reg  <= (accept && reject) ? rej_code : ERR_NONE;
        end
    end

    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;
`else
    assign reject    = 1'b0;
    assign err_valid = 1'b0;
    assign err_code  = ERR_NONE;
`endif

    // Address and word counter; a base load overrides the post-push advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (base_load) begin
                addr_reg <= base_addr;
            end else if (push) begin
                addr_reg <= addr_reg + 32'd4;
            end
            if (push) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
        end
    end

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({enc_instr, addr_reg}),
        .pop     (out_valid && out_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_instr = fifo_rd_data[63:32];
    assign out_addr  = fifo_rd_data[31:0];
    assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: reset values, a vector table,
// directed corner sequences and a randomized run against a queue model.
module tb_instr_encoder;
    localparam int DEPTH   = 2;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               base_load;
    logic [31:0]        base_addr;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_fmt;
    logic [2:0]         in_funct3;
    logic [4:0]         in_rd, in_rs1, in_rs2;
    logic [31:0]        in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [31:0]        out_addr;
    logic               err_valid;
    logic [1:0]         err_code;
    logic [COUNT_W-1:0] count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_load (base_load),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .count     (count)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl [5];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    // Reference encoding: shift/mask each immediate slice into its bit position.
    function automatic logic [31:0] enc_model(input logic [1:0] fmt, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] op, w;
        op = (fmt == 2'd0) ? 32'h13 : (fmt == 2'd1) ? 32'h03 : (fmt == 2'd2) ? 32'h23 : 32'h63;
        w  = (32'(rs1) << 15) | (32'(f3) << 12) | op;
        if (fmt < 2'd2)
            w |= ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
        else if (fmt == 2'd2)
            w |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
        else
            w |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                 (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        return w;
    endfunction

    // Reference legality rule; returns the error code, 0 when accepted.
    function automatic logic [1:0] rej_model(input logic [1:0] fmt, input logic [31:0] imm);
        logic [1:0] code;
        int         s;
        code = 2'b00;
        s    = $signed(imm);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if (fmt == 2'd3) begin
            if (s < -4096 || s > 4094) code = 2'b01;
            else if (imm[0])           code = 2'b10;
        end else if (s < -2048 || s > 2047) begin
            code = 2'b01;
        end
`else
        if (fmt == 2'd3 && s == 0) code = 2'b00;
`endif
        return code;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt = fmt; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Offer one request and hold it until consumed (bounded); returns #1 after the edge.
    task automatic send(input logic [1:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int n;
        n = 0;
        set_req(fmt, f3, rd, rs1, rs2, imm);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        $display("sent fmt=%0d imm=0x%08h", fmt, imm);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; base_load = 1'b0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        entry_t      q[$];
        entry_t      e;
        logic [31:0] m_addr, w0, w1, w2;
        logic [15:0] m_count;
        logic        m_err_v;
        logic [1:0]  m_err_c, code;
        logic        acc;

        tbl[0] = '{2'd0, 3'd0, 5'd1,  5'd2,  5'd0, 32'hFFFFFFFF, 32'hFFF10093, 32'h0};
        tbl[1] = '{2'd2, 3'd2, 5'd0,  5'd2,  5'd5, 32'd8,        32'h00512423, 32'h4};
        tbl[2] = '{2'd3, 3'd0, 5'd0,  5'd1,  5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 32'h8};
        tbl[3] = '{2'd1, 3'd2, 5'd5,  5'd10, 5'd0, 32'd16,       32'h01052283, 32'hC};
        tbl[4] = '{2'd3, 3'd1, 5'd0,  5'd3,  5'd4, 32'd8,        32'h00419463, 32'h10};

        in_valid = 0; base_load = 0; base_addr = 0; out_ready = 0;
        in_fmt = 0; in_funct3 = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr,      32'd0);
        chk("rst_out_addr",  out_addr,       32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_code",  32'(err_code),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one word at a time, drained immediately.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].fmt, tbl[i].f3, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].exp_instr);
            chk($sformatf("tbl%0d_addr", i),  out_addr,  tbl[i].exp_addr);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(i + 1));
        end
        @(negedge clk);

        // Immediate legality (addr now 0x14, count 5).
`ifdef INSTR_ENC_RANGE_CHECK_EN
        set_req(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("rng_err_valid", 32'(err_valid), 32'd1);
        chk("rng_err_code",  32'(err_code),  32'd1);
        chk("rng_no_out",    32'(out_valid), 32'd0);
        chk("rng_count",     32'(count),     32'd5);
        @(negedge clk);
        chk("rng_pulse_end", 32'(err_valid), 32'd0);
        set_req(2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        @(posedge clk); #1;
        set_req(2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4095);
        @(negedge clk);
        chk("odd_err_valid", 32'(err_valid), 32'd1);
        chk("odd_err_code",  32'(err_code),  32'd2);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_err_valid", 32'(err_valid), 32'd1);
        chk("b2b_err_code",  32'(err_code),  32'd1);
        send(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        @(negedge clk);
        chk("rng_next_addr", out_addr, 32'h14);
        chk("rng_next_err",  32'(err_valid), 32'd0);
`else
        send(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        @(negedge clk);
        chk("trunc_i_instr", out_instr, 32'h80000093);
        chk("trunc_i_addr",  out_addr,  32'h14);
        chk("trunc_i_err",   32'(err_valid), 32'd0);
        send(2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        @(negedge clk);
        chk("b_odd_instr", out_instr, 32'h00000163);
        chk("b_odd_err",   32'(err_valid), 32'd0);
`endif
        @(negedge clk);

        // Backpressure with a full FIFO.
        do_reset();
        out_ready = 1'b0;
        w0 = enc_model(2'd0, 3'd1, 5'd3, 5'd4, 5'd0, 32'd10);
        w1 = enc_model(2'd2, 3'd2, 5'd0, 5'd6, 5'd7, 32'hFFFFFFF0);
        w2 = enc_model(2'd1, 3'd0, 5'd8, 5'd9, 5'd0, 32'd100);
        send(2'd0, 3'd1, 5'd3, 5'd4, 5'd0, 32'd10);
        send(2'd2, 3'd2, 5'd0, 5'd6, 5'd7, 32'hFFFFFFF0);
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        set_req(2'd1, 3'd0, 5'd8, 5'd9, 5'd0, 32'd100);
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_push_count", 32'(count), 32'd2);
        chk("bp_head0_instr", out_instr, w0);
        chk("bp_head0_addr",  out_addr,  32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_head1_instr", out_instr, w1);
        chk("bp_head1_addr",  out_addr,  32'h4);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_head2_instr", out_instr, w2);
        chk("bp_head2_addr",  out_addr,  32'h8);
        chk("bp_count",       32'(count), 32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // base_load coinciding with a push, then address wrap.
        do_reset();
        out_ready = 1'b0;
        set_req(2'd0, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1);
        base_load = 1'b1; base_addr = 32'h100;
        @(posedge clk); #1;
        base_load = 1'b0; in_valid = 1'b0;
        send(2'd0, 3'd0, 5'd2, 5'd2, 5'd0, 32'd2);
        @(negedge clk);
        chk("bl_old_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bl_new_addr", out_addr, 32'h100);
        @(posedge clk);
        @(negedge clk);
        base_load = 1'b1; base_addr = 32'hFFFFFFFC;
        @(posedge clk); #1;
        base_load = 1'b0; out_ready = 1'b0;
        send(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        send(2'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("wrap_addr0", out_addr, 32'hFFFFFFFC);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_addr1", out_addr, 32'h0);

        // Asynchronous reset with two words queued.
        do_reset();
        out_ready = 1'b0;
        send(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        send(2'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd6);
        @(negedge clk);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd1);
        chk("ar_count",     32'(count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the queue model.
        q.delete();
        m_addr = 0; m_count = 0; m_err_v = 0; m_err_c = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_out_instr", out_instr, q[0].instr);
                chk("rnd_out_addr",  out_addr,  q[0].addr);
            end
            chk("rnd_in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
            chk("rnd_count",     32'(count),     32'(m_count));
            chk("rnd_err_valid", 32'(err_valid), 32'(m_err_v));
            chk("rnd_err_code",  32'(err_code),  32'(m_err_c));

            in_valid  = ($urandom_range(0, 3) != 0);
            in_fmt    = 2'($urandom_range(0, 3));
            in_funct3 = 3'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom;
                1:       in_imm = 32'($urandom_range(0, 8400)) - 32'd4200;
                default: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            base_load = ($urandom_range(0, 15) == 0);
            base_addr = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFFFFFC) : 32'hFFFFFFF8;

            @(posedge clk);
            acc  = in_valid && (q.size() < DEPTH);
            code = rej_model(in_fmt, in_imm);
            e.instr = enc_model(in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm);
            e.addr  = m_addr;
            if (q.size() != 0 && out_ready) begin
                $display("pop  0x%08h @0x%08h", q[0].instr, q[0].addr);
                void'(q.pop_front());
            end
            if (acc && code == 2'b00) begin
                q.push_back(e);
                m_count++;
            end
            m_err_v = acc && (code != 2'b00);
            m_err_c = m_err_v ? code : 2'b00;
            if (base_load) m_addr = base_addr;
            else if (acc && code == 2'b00) m_addr = m_addr + 32'd4;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
